// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the IF/MEM memory-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - arb_owner_t : which pipeline stage owns the current transaction
//   - cnt_width() : width of a counter that must hold values 0..lim
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_t;

   // A counter saturating at lim needs to represent lim itself.
   function automatic int unsigned cnt_width(input int unsigned lim);
      return (lim < 2) ? 1 : $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_starve_ctr
//   Saturating counter of consecutive data grants that beat a waiting fetch.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     i_inc      : data won while fetch was eligible (saturates at STARVE_LIM)
//     i_clr      : fetch was granted (clear has priority over increment)
//     o_at_lim   : counter equals STARVE_LIM, fetch must win next time
//     o_cnt      : current count
// ---------------------------------------------------------------------------
module mem_port_arbiter_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter  int unsigned STARVE_LIM = 3,
   localparam int unsigned CNT_W      = cnt_width(STARVE_LIM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic             o_at_lim,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_at_lim = (r_cnt == LIM);
   assign o_cnt    = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single-port memory between instruction fetch (IF) and the data
//   stage (MEM). One transaction outstanding at a time; data has priority,
//   but after STARVE_LIM (>= 1) consecutive data wins over a waiting fetch
//   the fetch is forced through.
//
//   Handshake rule (all sides): a transfer happens in a cycle where valid
//   and ready are both high. Requesters keep valid/fields stable until ready;
//   the arbiter keeps mem_req_* stable until mem_req_ready. Responses are
//   single-cycle pulses with no back-pressure.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     if_req_valid/addr/ready       fetch request channel
//     if_flush                      redirect: kill pending/in-flight fetch
//     if_rsp_valid/data             fetch response (registered pulse)
//     d_req_valid/we/addr/wdata/ready  data request channel
//     d_rsp_valid/rdata             load data / store ack (registered pulse)
//     mem_req_valid/we/addr/wdata/ready  memory request channel
//     mem_rsp_valid/rdata           memory read response
//     dbg_state, dbg_starve_cnt     FSM state and starvation counter
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter  int unsigned ADDR_W     = 32,
   parameter  int unsigned DATA_W     = 32,
   parameter  int unsigned STARVE_LIM = 3,
   localparam int unsigned CNT_W      = cnt_width(STARVE_LIM)
) (
   input  logic              clk,
   input  logic              rst,
   // fetch side
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   input  logic              if_flush,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   // data side
   input  logic              d_req_valid,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_rdata,
   // memory side
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   // debug
   output arb_state_t        dbg_state,
   output logic [CNT_W-1:0]  dbg_starve_cnt
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   arb_owner_t        r_owner;
   logic              r_drop;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_if_rsp_valid;
   logic [DATA_W-1:0] r_if_rsp_data;
   logic              r_d_rsp_valid;
   logic [DATA_W-1:0] r_d_rsp_rdata;

   logic              w_if_elig;
   logic              w_at_lim;
   logic              w_grant_if;
   logic              w_grant_d;
   logic              w_in_flight;
   logic [CNT_W-1:0]  w_cnt;

   // A fetch being flushed this cycle is already stale and must not win.
   assign w_if_elig = if_req_valid && !if_flush;

   // Data wins by default; fetch wins only when data is idle or when the
   // starvation counter has reached its limit while fetch is waiting.
   assign w_grant_d  = (r_state == IDLE) && d_req_valid && !(w_if_elig && w_at_lim);
   assign w_grant_if = (r_state == IDLE) && w_if_elig && (!d_req_valid || w_at_lim);

   assign w_in_flight = (r_state == ISSUE) || (r_state == WAIT);

   mem_port_arbiter_starve_ctr #(
      .STARVE_LIM (STARVE_LIM)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_grant_d && w_if_elig),
      .i_clr    (w_grant_if),
      .o_at_lim (w_at_lim),
      .o_cnt    (w_cnt)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_grant_d || w_grant_if) w_next_state = ISSUE;
         ISSUE:   if (mem_req_ready)           w_next_state = r_we ? IDLE : WAIT;
         WAIT:    if (mem_rsp_valid)           w_next_state = IDLE;
         default:                              w_next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Grants are combinational and only ever offered in IDLE; they are held
   // off while reset is asserted so nothing is accepted and then discarded.
   always_comb begin
      if_req_ready  = w_grant_if && !rst;
      d_req_ready   = w_grant_d  && !rst;
      mem_req_valid = (r_state == ISSUE);
      mem_req_we    = r_we;
      mem_req_addr  = r_addr;
      mem_req_wdata = r_wdata;
   end

   // ---------------- latched request and responses ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner        <= OWN_IF;
         r_drop         <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_if_rsp_valid <= 1'b0;
         r_if_rsp_data  <= '0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rsp_rdata  <= '0;
      end else begin
         r_if_rsp_valid <= 1'b0;
         r_d_rsp_valid  <= 1'b0;

         if (w_grant_d) begin
            r_owner <= OWN_D;
            r_we    <= d_req_we;
            r_addr  <= d_req_addr;
            r_wdata <= d_req_wdata;
            r_drop  <= 1'b0;
         end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= if_req_addr;
            r_wdata <= '0;
            r_drop  <= 1'b0;
         end

         // The memory transaction is left to complete; only the response
         // delivery to fetch is suppressed.
         if (w_in_flight && (r_owner == OWN_IF) && if_flush) begin
            r_drop <= 1'b1;
         end

         // Only data ever writes, so a write ack always goes to data.
         if ((r_state == ISSUE) && mem_req_ready && r_we) begin
            r_d_rsp_valid <= 1'b1;
            r_d_rsp_rdata <= '0;
         end

         if ((r_state == WAIT) && mem_rsp_valid) begin
            if (r_owner == OWN_D) begin
               r_d_rsp_valid <= 1'b1;
               r_d_rsp_rdata <= mem_rsp_rdata;
            end else if (!r_drop && !if_flush) begin
               r_if_rsp_valid <= 1'b1;
               r_if_rsp_data  <= mem_rsp_rdata;
            end
         end
      end
   end

   assign if_rsp_valid   = r_if_rsp_valid;
   assign if_rsp_data    = r_if_rsp_data;
   assign d_rsp_valid    = r_d_rsp_valid;
   assign d_rsp_rdata    = r_d_rsp_rdata;
   assign dbg_state      = r_state;
   assign dbg_starve_cnt = w_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench: a cycle-by-cycle vector table (inputs + expected outputs)
//   followed by hand-written starvation, back-pressure and reset sequences.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam logic [31:0] S_I = 32'd0;
   localparam logic [31:0] S_S = 32'd1;
   localparam logic [31:0] S_W = 32'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
   logic [31:0] if_req_addr, if_rsp_data;
   logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
   logic        mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
   arb_state_t  dbg_state;
   logic [1:0]  dbg_starve_cnt;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIM(3)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] if_v, if_a, fl, d_v, d_we, d_a, d_wd, m_rdy, m_rv, m_rd;
      logic [31:0] e_ifr, e_dr, e_mv, e_mwe, e_ma, e_mwd, e_ifv, e_ifd, e_dv, e_dd, e_st, e_cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add(
      input logic [31:0] if_v, if_a, fl, d_v, d_we, d_a, d_wd, m_rdy, m_rv, m_rd,
      input logic [31:0] e_ifr, e_dr, e_mv, e_mwe, e_ma, e_mwd, e_ifv, e_ifd, e_dv, e_dd, e_st, e_cnt);
      vec_t v;
      v.if_v = if_v; v.if_a = if_a; v.fl = fl; v.d_v = d_v; v.d_we = d_we; v.d_a = d_a;
      v.d_wd = d_wd; v.m_rdy = m_rdy; v.m_rv = m_rv; v.m_rd = m_rd;
      v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_mv = e_mv; v.e_mwe = e_mwe; v.e_ma = e_ma;
      v.e_mwd = e_mwd; v.e_ifv = e_ifv; v.e_ifd = e_ifd; v.e_dv = e_dv; v.e_dd = e_dd;
      v.e_st = e_st; v.e_cnt = e_cnt;
      vq.push_back(v);
   endtask

   // ---------------- driver ----------------
   task automatic set_in(input logic [31:0] ifv, ifa, fl, dv, dwe, da, dwd, mr, mv, md);
      if_req_valid  = ifv[0];
      if_req_addr   = ifa;
      if_flush      = fl[0];
      d_req_valid   = dv[0];
      d_req_we      = dwe[0];
      d_req_addr    = da;
      d_req_wdata   = dwd;
      mem_req_ready = mr[0];
      mem_rsp_valid = mv[0];
      mem_rsp_rdata = md;
   endtask

   byte         exp_order[5] = '{"D", "D", "D", "I", "D"};
   logic [31:0] exp_cnt[5]   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

   initial begin
      int ng, ns, n_drsp, n_ifrsp;
      vec_t v;

      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // inputs:  if_v if_a fl | d_v we d_a d_wd | m_rdy m_rv m_rd
      // expect:  ifr dr | mv mwe ma mwd | ifv ifd | dv dd | state cnt
      // reset state
      add(0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      // fetch-only read of 0x100
      add(1, 'h100, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h100, 0,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 1, 'h13,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  1, 'h13,  0, 0,  S_I, 0);
      // simultaneous fetch 0x200 / load 0x400: data first, then fetch
      add(1, 'h200, 0,  1, 0, 'h400, 0,  1, 0, 0,  0, 1,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(1, 'h200, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h400, 0,  0, 0,  0, 0,  S_S, 1);
      add(1, 'h200, 0,  0, 0, 0, 0,  1, 1, 'hCAFE0001,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 1);
      add(1, 'h200, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0,  1, 'hCAFE0001,  S_I, 1);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h200, 0,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 1, 'h93,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  1, 'h93,  0, 0,  S_I, 0);
      // store 0x500, ack with rdata 0; stray mem_rsp_valid in IDLE ignored
      add(0, 0, 0,  1, 1, 'h500, 'h12345678,  1, 0, 0,  0, 1,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 1, 'h500, 'h12345678,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 1, 'hFFFFFFFF,  0, 0,  0, 0, 0, 0,  0, 0,  1, 0,  S_I, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      // fetch with flush in IDLE is not eligible
      add(1, 'h2FC, 1,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      // fetch 0x300, flush in WAIT, response dropped, next fetch normal
      add(1, 'h300, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h300, 0,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 1,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 1, 'hDEADBEEF,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(1, 'h304, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h304, 0,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 1, 'h00100073,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  1, 'h00100073,  0, 0,  S_I, 0);
      // flush coinciding with mem_rsp_valid drops the fetch response
      add(1, 'h308, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h308, 0,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 1,  0, 0, 0, 0,  1, 1, 'h11111111,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      // flush has no effect on a data load
      add(0, 0, 0,  1, 0, 'h600, 0,  1, 0, 0,  0, 1,  0, 0, 0, 0,  0, 0,  0, 0,  S_I, 0);
      add(0, 0, 1,  0, 0, 0, 0,  1, 0, 0,  0, 0,  1, 0, 'h600, 0,  0, 0,  0, 0,  S_S, 0);
      add(0, 0, 1,  0, 0, 0, 0,  1, 1, 'h600D0600,  0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  S_W, 0);
      add(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0,  1, 'h600D0600,  S_I, 0);

      foreach (vq[i]) begin
         v = vq[i];
         @(negedge clk);
         set_in(v.if_v, v.if_a, v.fl, v.d_v, v.d_we, v.d_a, v.d_wd, v.m_rdy, v.m_rv, v.m_rd);
         #1;
         chk($sformatf("v%0d if_req_ready", i), 32'(if_req_ready), v.e_ifr);
         chk($sformatf("v%0d d_req_ready", i), 32'(d_req_ready), v.e_dr);
         chk($sformatf("v%0d mem_req_valid", i), 32'(mem_req_valid), v.e_mv);
         if (v.e_mv[0]) begin
            chk($sformatf("v%0d mem_req_we", i), 32'(mem_req_we), v.e_mwe);
            chk($sformatf("v%0d mem_req_addr", i), mem_req_addr, v.e_ma);
            chk($sformatf("v%0d mem_req_wdata", i), mem_req_wdata, v.e_mwd);
         end
         chk($sformatf("v%0d if_rsp_valid", i), 32'(if_rsp_valid), v.e_ifv);
         if (v.e_ifv[0]) chk($sformatf("v%0d if_rsp_data", i), if_rsp_data, v.e_ifd);
         chk($sformatf("v%0d d_rsp_valid", i), 32'(d_rsp_valid), v.e_dv);
         if (v.e_dv[0]) chk($sformatf("v%0d d_rsp_rdata", i), d_rsp_rdata, v.e_dd);
         chk($sformatf("v%0d state", i), 32'(dbg_state), v.e_st);
         chk($sformatf("v%0d starve_cnt", i), 32'(dbg_starve_cnt), v.e_cnt);
      end

      // ---------------- starvation: fetch held, 4 back-to-back stores ----------------
      // Memory always ready and always presenting a response (ignored outside WAIT).
      ng = 0; ns = 0; n_drsp = 0; n_ifrsp = 0;
      for (int cyc = 0; cyc < 80 && ng < 5; cyc++) begin
         @(negedge clk);
         set_in(1, 'hA00, 0, (ns < 4) ? 1 : 0, 1, 'h700 + 4 * ns, ns + 1, 1, 1, 'h55);
         #1;
         if (d_rsp_valid) begin
            n_drsp++;
            chk("starve store_ack_rdata", d_rsp_rdata, 0);
         end
         if (if_rsp_valid) begin
            n_ifrsp++;
            chk("starve fetch_data", if_rsp_data, 'h55);
         end
         if (d_req_ready || if_req_ready) begin
            chk($sformatf("starve grant%0d", ng), d_req_ready ? 32'("D") : 32'("I"), 32'(exp_order[ng]));
            chk($sformatf("starve cnt%0d", ng), 32'(dbg_starve_cnt), exp_cnt[ng]);
            if (d_req_ready) ns++;
            ng++;
         end
      end
      chk("starve grants_seen", ng, 5);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h55);
         #1;
         if (d_rsp_valid) begin
            n_drsp++;
            chk("starve store_ack_rdata", d_rsp_rdata, 0);
         end
         if (if_rsp_valid) n_ifrsp++;
      end
      chk("starve store_acks", n_drsp, 4);
      chk("starve fetch_rsps", n_ifrsp, 1);
      chk("starve end_state", 32'(dbg_state), S_I);

      // ---------------- back-pressure: mem_req_ready low for 5 cycles ----------------
      @(negedge clk);
      set_in(0, 0, 0, 1, 1, 'h800, 'hA5A5A5A5, 0, 0, 0);
      #1;
      chk("bp d_req_ready", 32'(d_req_ready), 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         #1;
         chk($sformatf("bp%0d mem_req_valid", k), 32'(mem_req_valid), 1);
         chk($sformatf("bp%0d mem_req_addr", k), mem_req_addr, 'h800);
         chk($sformatf("bp%0d mem_req_wdata", k), mem_req_wdata, 'hA5A5A5A5);
         chk($sformatf("bp%0d mem_req_we", k), 32'(mem_req_we), 1);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      chk("bp accept mem_req_valid", 32'(mem_req_valid), 1);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("bp d_rsp_valid", 32'(d_rsp_valid), 1);
      chk("bp d_rsp_rdata", d_rsp_rdata, 0);
      chk("bp state", 32'(dbg_state), S_I);

      // ---------------- reset in WAIT, then a stray response ----------------
      @(negedge clk);
      set_in(1, 'h900, 0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      chk("rstw if_req_ready", 32'(if_req_ready), 1);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      chk("rstw state_issue", 32'(dbg_state), S_S);
      @(negedge clk);
      #1;
      chk("rstw state_wait", 32'(dbg_state), S_W);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst if_req_ready", 32'(if_req_ready), 0);
      chk("rst d_req_ready", 32'(d_req_ready), 0);
      chk("rst mem_req_valid", 32'(mem_req_valid), 0);
      chk("rst mem_req_we", 32'(mem_req_we), 0);
      chk("rst mem_req_addr", mem_req_addr, 0);
      chk("rst mem_req_wdata", mem_req_wdata, 0);
      chk("rst if_rsp_valid", 32'(if_rsp_valid), 0);
      chk("rst if_rsp_data", if_rsp_data, 0);
      chk("rst d_rsp_valid", 32'(d_rsp_valid), 0);
      chk("rst d_rsp_rdata", d_rsp_rdata, 0);
      chk("rst state", 32'(dbg_state), S_I);
      chk("rst starve_cnt", 32'(dbg_starve_cnt), 0);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hBAD0BAD0);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("stray if_rsp_valid", 32'(if_rsp_valid), 0);
      chk("stray d_rsp_valid", 32'(d_rsp_valid), 0);
      chk("stray state", 32'(dbg_state), S_I);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch stage (IF) and data-memory stage (MEM).
- Holds at most one outstanding transaction, with valid/ready handshakes on every side.
- Data requests have priority; a starvation bound guarantees fetch progress.
- A fetch flush input (branch-taken redirect) discards a stale in-flight fetch response.
- The pipeline stalls on the deasserted ready/response signals.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIM, 3, consecutive data grants won over a waiting fetch before fetch is forced to win (must be ≥1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_flush  in  1  kill pending or in-flight fetch.
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse).
- if_rsp_data  out  DATA_W  fetched instruction.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_W  data address.
- d_req_wdata  in  DATA_W  store data.
- d_req_ready  out  1  data request accepted this cycle.
- d_rsp_valid  out  1  load data or store acknowledge (1-cycle pulse).
- d_rsp_rdata  out  DATA_W  load data; 0 for store acknowledge.
- mem_req_valid  out  1  request to memory.
- mem_req_we  out  1  write enable.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, owner = IF, drop flag = 0, starve_cnt = 0.
  - All outputs 0; latched address/data registers 0.
  - Any in-flight transaction is abandoned; a later mem_rsp_valid for it is ignored.
- States and transitions:
  - IDLE → ISSUE on a grant.
  - ISSUE → IDLE on an accepted write; ISSUE → WAIT on an accepted read.
  - WAIT → IDLE on mem_rsp_valid.
- IDLE grant selection:
  - Fetch is eligible when if_req_valid && !if_flush.
  - Data wins when d_req_valid, unless (fetch eligible && starve_cnt == STARVE_LIM); in that case fetch wins.
  - Fetch wins when it is eligible and data is not requesting.
  - The winner's *_req_ready is asserted combinationally in this cycle only. Its addr/we/wdata are latched, owner is recorded, drop flag is cleared.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIM) when data is granted while fetch is eligible.
  - Cleared when fetch is granted.
  - Unchanged otherwise.
- ISSUE:
  - mem_req_valid = 1, driven from the latched fields; held stable until mem_req_ready.
  - Write accepted: d_rsp_valid pulses in the next cycle with d_rsp_rdata = 0.
  - Read accepted: go to WAIT.
- WAIT:
  - On mem_rsp_valid, route mem_rsp_rdata to the owner. *_rsp_valid and *_rsp_data are registered, so they appear one cycle later.
  - Then return to IDLE.
- Flush:
  - if_flush while owner = IF in ISSUE or WAIT sets the drop flag.
  - The memory transaction still completes, but if_rsp_valid is suppressed.
  - if_flush in the same cycle as mem_rsp_valid also drops the response.
  - Flush has no effect on a data transaction.
- if_req_ready and d_req_ready are 0 outside IDLE; new grants are possible only in IDLE.
- Minimum read latency: request accepted in cycle N, mem_req_valid in N+1, mem_rsp_valid no earlier than N+2, response in N+3, next grant in N+3.
- mem_rsp_valid outside WAIT is ignored.
- rsp_valid pulses are never asserted for more than one cycle per transaction.

Decomposition:
- rv32_pkg gains `arb_state_t` (IDLE, ISSUE, WAIT) and `arb_owner_t` (OWN_IF, OWN_D).
- Optional sub-module `arb_starve_ctr`: a saturating counter with inc/clr inputs and an at_lim output, parameterised by STARVE_LIM.
- All other logic stays flat.

Test Plan:
- Fetch-only read: if_req addr 0x100; memory ready immediately, rsp 0x00000013 one cycle later → if_req_ready in cycle 0, mem_req_valid in cycle 1, if_rsp_valid with 0x00000013 in cycle 3.
- Simultaneous requests: fetch 0x200 and data load 0x400 in the same cycle → data granted first, fetch granted on return to IDLE, starve_cnt = 1 then 0.
- Starvation: fetch held valid while data issues 4 back-to-back stores, STARVE_LIM = 3 → grant order D, D, D, IF, D; each store yields d_rsp_valid with rdata 0.
- Flush: fetch read to 0x300; if_flush pulses in WAIT; mem_rsp_valid returns 0xDEADBEEF → no if_rsp_valid, state back to IDLE, next fetch proceeds normally.
- Backpressure and reset: mem_req_ready held low for 5 cycles → mem_req_valid, addr and wdata stay stable throughout. rst asserted mid-WAIT → next cycle all outputs 0 and state IDLE; a subsequent stray mem_rsp_valid produces no response.
